// File: rtl/dense1_sigmoid_tx.sv
// Dense1 output buffer with piecewise-linear sigmoid, streamed to dense2.
// One element per enabled cycle, framed by frame_start/frame_end flags.
module dense1_sigmoid_tx #(
    parameter int N      = 120,
    parameter int DATA_W = 16,
    parameter int AW     = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_wr_en,
    input  logic [AW-1:0]     in_wr_addr,
    input  logic [DATA_W-1:0] in_wr_data,
    input  logic              in_done,
    output logic              busy,
    output logic              frame_start_out,
    output logic              frame_end_out,
    output logic [DATA_W-1:0] dense_sigmoid_out,
    output logic              valid_out
);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              fs_q, fs_d;
    logic              fe_q, fe_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] buf_q [N];

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    // |x| saturates at 32767 so -32768 maps to the same output as -32767
    function automatic logic [DATA_W-1:0] sig(
        input logic [DATA_W-1:0] x
    );
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] y;
        a = x[DATA_W-1] ? -x : x;
        if (a[DATA_W-1]) a = {1'b0, {(DATA_W-1){1'b1}}};
        if (a >= DATA_W'(1280))
            y = DATA_W'(256);
        else if (a >= DATA_W'(608))
            y = (a >> 5) + DATA_W'(216);
        else if (a >= DATA_W'(256))
            y = (a >> 3) + DATA_W'(160);
        else
            y = (a >> 2) + DATA_W'(128);
        return x[DATA_W-1] ? DATA_W'(256) - y : y;
    endfunction

    logic addr_ok;
    assign addr_ok = {1'b0, in_wr_addr} < (AW+1)'(N);

    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_wr_en && addr_ok)
            buf_q[in_wr_addr] <= in_wr_data;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        fs_d    = 1'b0;
        fe_d    = 1'b0;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (in_done) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (ena) begin
                    dout_d  = sig(buf_q[cnt_q]);
                    valid_d = 1'b1;
                    fs_d    = (cnt_q == '0);
                    fe_d    = (cnt_q == LAST);
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
            dout_q  <= dout_d;
        end
    end

    assign busy              = (state_q == STREAM);
    assign valid_out         = valid_q;
    assign frame_start_out   = fs_q;
    assign frame_end_out     = fe_q;
    assign dense_sigmoid_out = dout_q;

endmodule

// File: tb/tb_dense1_sigmoid_tx.sv
// Bench for dense1_sigmoid_tx: frame-queue model checked every cycle,
// plus literal expectations on captured frames.
module tb_dense1_sigmoid_tx;

    localparam int N  = 120;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          in_wr_en;
    logic [AW-1:0] in_wr_addr;
    logic [15:0]   in_wr_data;
    logic          in_done;
    logic          busy;
    logic          frame_start_out;
    logic          frame_end_out;
    logic [15:0]   dense_sigmoid_out;
    logic          valid_out;

    dense1_sigmoid_tx #(.N(N)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ena               (ena),
        .in_wr_en          (in_wr_en),
        .in_wr_addr        (in_wr_addr),
        .in_wr_data        (in_wr_data),
        .in_done           (in_done),
        .busy              (busy),
        .frame_start_out   (frame_start_out),
        .frame_end_out     (frame_end_out),
        .dense_sigmoid_out (dense_sigmoid_out),
        .valid_out         (valid_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int msig(int x);
        int a;
        int y;
        a = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        if (a >= 1280)     y = 256;
        else if (a >= 608) y = a / 32 + 216;
        else if (a >= 256) y = a / 8 + 160;
        else               y = a / 4 + 128;
        return (x < 0) ? 256 - y : y;
    endfunction

    // Model: a frame is a queue of expected sigmoid values snapshotted
    // when in_done is accepted; each enabled cycle pops one element.
    int mbuf [N];
    int exp_q [$];
    int m_val;
    int m_pos;
    bit m_valid, m_fs, m_fe;

    initial for (int i = 0; i < N; i++) mbuf[i] = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_val = 0; m_valid = 0; m_fs = 0; m_fe = 0;
        end else begin
            m_valid = 0; m_fs = 0; m_fe = 0;
            if (exp_q.size() == 0) begin
                if (in_wr_en && int'(in_wr_addr) < N)
                    mbuf[in_wr_addr] = int'($signed(in_wr_data));
                if (in_done)
                    for (int i = 0; i < N; i++) exp_q.push_back(msig(mbuf[i]));
            end else if (ena) begin
                m_pos   = N - exp_q.size();
                m_val   = exp_q.pop_front();
                m_valid = 1;
                m_fs    = (m_pos == 0);
                m_fe    = (m_pos == N - 1);
            end
        end
    end

    int cyc = 0;
    int got [$];
    int nstart = 0, nend = 0, extra_start = 0, gap = 0;
    int start_cyc = 0, end_cyc = 0;
    bit in_frame = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_frame = 0;
        end else begin
            chk("valid_out", int'(valid_out), int'(m_valid));
            chk("frame_start_out", int'(frame_start_out), int'(m_fs));
            chk("frame_end_out", int'(frame_end_out), int'(m_fe));
            chk("dense_sigmoid_out", int'(dense_sigmoid_out), m_val);
            chk("busy", int'(busy), int'(exp_q.size() != 0));
            if (valid_out) begin
                if (frame_start_out) begin
                    if (in_frame) extra_start++;
                    got.delete();
                    gap = 0;
                    nstart++;
                    start_cyc = cyc;
                    in_frame = 1;
                end
                got.push_back(int'(dense_sigmoid_out));
                if (frame_end_out) begin
                    nend++;
                    end_cyc = cyc;
                    in_frame = 0;
                end
            end else if (in_frame) begin
                gap++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int addr, int data);
        in_wr_en   = 1;
        in_wr_addr = AW'(addr);
        in_wr_data = 16'(data);
        tick();
        in_wr_en = 0;
    endtask

    task automatic done_pulse();
        in_done = 1;
        tick();
        in_done = 0;
    endtask

    task automatic wait_end(int max);
        int k = 0;
        while (!frame_end_out && k < max) begin
            tick();
            k++;
        end
        if (!frame_end_out) chk("frame_end timeout", 0, 1);
    endtask

    int pts [8] = '{0, 256, -256, 512, 608, 1280, -32768, 32767};
    int pexp [8] = '{128, 192, 64, 224, 235, 256, 0, 256};
    int s0, e0, n0;

    initial begin
        rst_n = 0; ena = 0; in_wr_en = 0; in_wr_addr = '0;
        in_wr_data = '0; in_done = 0;
        repeat (2) tick();
        chk("reset busy", int'(busy), 0);
        chk("reset valid", int'(valid_out), 0);
        chk("reset dout", int'(dense_sigmoid_out), 0);
        rst_n = 1;
        tick();

        for (int i = 0; i < N; i++) wr(i, (i < 8) ? pts[i] : 0);
        ena = 1;
        done_pulse();
        wait_end(200);
        repeat (2) tick();
        for (int i = 0; i < 8; i++)
            chk($sformatf("sig point %0d", i), got[i], pexp[i]);

        for (int i = 0; i < N - 1; i++) wr(i, i);
        in_wr_en = 1; in_wr_addr = AW'(N - 1); in_wr_data = 16'(N - 1);
        in_done = 1;
        tick();
        in_wr_en = 0; in_done = 0;
        n0 = nstart;
        wait_end(200);
        repeat (2) tick();
        chk("frame length", got.size(), N);
        chk("frame starts", nstart - n0, 1);
        chk("frame elem 119", got[119], 157);
        chk("frame gap", gap, 0);

        done_pulse();
        repeat (6) tick();
        ena = 0;
        repeat (3) tick();
        ena = 1;
        wait_end(200);
        repeat (2) tick();
        chk("stall length", got.size(), N);
        chk("stall gap", gap, 3);
        chk("stall elem 6", got[6], 129);

        done_pulse();
        repeat (10) tick();
        in_wr_en = 1; in_wr_addr = AW'(100); in_wr_data = 16'(1280);
        in_done = 1;
        tick();
        in_wr_en = 0; in_done = 0;
        wait_end(200);
        repeat (2) tick();
        chk("protected elem 100", got[100], 153);
        chk("extra start", extra_start, 0);

        done_pulse();
        wait_end(200);
        done_pulse();
        e0 = end_cyc;
        wait_end(200);
        s0 = start_cyc;
        chk("back-to-back gap", s0 - e0, 2);
        repeat (2) tick();
        chk("b2b length", got.size(), N);

        n0 = nend;
        done_pulse();
        repeat (50) tick();
        rst_n = 0;
        #1;
        chk("rst valid", int'(valid_out), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst start", int'(frame_start_out), 0);
        chk("rst end", int'(frame_end_out), 0);
        tick();
        rst_n = 1;
        tick();
        chk("rst no frame_end", nend - n0, 0);
        done_pulse();
        wait_end(200);
        repeat (2) tick();
        chk("post-rst length", got.size(), N);
        chk("post-rst elem 0", got[0], 128);
        chk("post-rst elem 100", got[100], 153);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
